// File: rtl/io_test_scope.sv
// rtl/io_test_scope.sv - triggered 2^CDepthLog2 x 16 capture scope behind a small IO register window
module io_test_scope #(
  parameter logic [15:0] CAddrBase  = 16'h0000,
  parameter int          CDepthLog2 = 6
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  output logic [63:0] AIoMiso,
  input  logic [63:0] AIoMosi,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr,
  input  logic [15:0] ATest16p,
  output logic        ABusy
);

  localparam int Depth = 1 << CDepthLog2;
  localparam int PtrW  = CDepthLog2 + 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [PtrW-1:0] PtrEnd  = PtrW'(Depth);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  localparam logic [3:0] SzByte  = 4'b0001;
  localparam logic [3:0] SzWord  = 4'b0010;
  localparam logic [3:0] SzDword = 4'b0100;

  logic [1:0]      state;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [15:0]     trig_value;
  logic [15:0]     trig_mask;
  logic [15:0]     mem [Depth];

  logic [15:0]      offset;
  logic             hit0, hit1, hit2, in_range;
  logic             wr_any, rd_any, wr_ok, rd_ok, bad;
  logic             cmd_wr_ok, trig_wr_ok, status_rd_ok, data_rd_ok;
  logic             do_cmd, do_arm, do_abort, do_trig_wr, do_data_rd;
  logic             data_valid, trig_hit, mem_we;
  logic [PtrW-2:0]  mem_addr;
  logic [15:0]      data_out;
  logic [7:0]       status;
  logic             unused_mosi;

  assign unused_mosi = ^AIoMosi[63:32];

  // Address/size decode, register read mux and capture write control; all combinational on the current access
  always_comb begin
    offset       = AIoAddr - CAddrBase;
    hit0         = (offset == 16'd0);
    hit1         = (offset == 16'd1);
    hit2         = (offset == 16'd2);
    in_range     = hit0 || hit1 || hit2;
    wr_any       = |AIoWrSize;
    rd_any       = |AIoRdSize;
    cmd_wr_ok    = hit0 && (AIoWrSize == SzByte);
    trig_wr_ok   = hit1 && (AIoWrSize == SzDword);
    status_rd_ok = hit0 && (AIoRdSize == SzByte);
    data_rd_ok   = hit2 && (AIoRdSize == SzWord);
    wr_ok        = cmd_wr_ok || trig_wr_ok;
    rd_ok        = status_rd_ok || data_rd_ok;
    // An illegal half of an access poisons the whole access so it has no side effect.
    bad          = in_range && ((wr_any && !wr_ok) || (rd_any && !rd_ok));
    AIoAddrErr   = bad;
    AIoAddrAck   = (wr_ok || rd_ok) && !bad;

    do_cmd       = AClkHEn && AIoAddrAck && cmd_wr_ok;
    do_abort     = do_cmd && AIoMosi[1];
    do_arm       = do_cmd && AIoMosi[0] && !AIoMosi[1];
    do_trig_wr   = AClkHEn && AIoAddrAck && trig_wr_ok;

    data_valid   = (state == StDone) && (rd_ptr != PtrEnd);
    data_out     = data_valid ? mem[rd_ptr[PtrW-2:0]] : 16'h0000;
    do_data_rd   = AClkHEn && AIoAddrAck && data_rd_ok && data_valid;

    status       = {5'h00, state == StDone, state == StCapture, state == StArmed};
    AIoMiso      = 64'h0;
    if (AIoAddrAck && status_rd_ok) AIoMiso = {56'h0, status};
    else if (AIoAddrAck && data_rd_ok) AIoMiso = {48'h0, data_out};

    trig_hit     = ((ATest16p ^ trig_value) & trig_mask) == 16'h0000;
    mem_we       = AClkHEn && !do_cmd_override(do_arm, do_abort) &&
                   (((state == StArmed) && trig_hit) || (state == StCapture));
    mem_addr     = (state == StArmed) ? '0 : wr_ptr[PtrW-2:0];

    ABusy        = (state == StArmed) || (state == StCapture);
  end

  function automatic logic do_cmd_override(input logic arm, input logic abort);
    return arm || abort;
  endfunction

  // Scope FSM, pointers and trigger registers; abort beats arm, arm beats everything else
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state      <= StIdle;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_value <= 16'h0000;
      trig_mask  <= 16'h0000;
    end else if (AClkHEn) begin
      if (do_trig_wr) begin
        trig_value <= AIoMosi[15:0];
        trig_mask  <= AIoMosi[31:16];
      end
      if (do_abort) begin
        state <= StIdle;
      end else if (do_arm) begin
        state  <= StArmed;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        case (state)
          StArmed: begin
            if (trig_hit) begin
              wr_ptr <= PtrW'(1);
              state  <= StCapture;
            end
          end
          StCapture: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == PtrLast) state <= StDone;
          end
          StDone: begin
            if (do_data_rd) rd_ptr <= rd_ptr + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sample buffer: single write port from the capture path, combinational read for DATA
  always_ff @(posedge AClkH) begin
    if (mem_we) mem[mem_addr] <= ATest16p;
  end

endmodule

// File: tb/tb_io_test_scope.sv
// tb/tb_io_test_scope.sv - directed vector bench for io_test_scope
module tb_io_test_scope;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] addr;
  logic [63:0] miso;
  logic [63:0] mosi;
  logic [3:0]  wr_size;
  logic [3:0]  rd_size;
  logic        ack;
  logic        err;
  logic [15:0] test;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  io_test_scope dut (
    .AClkH      (clk),
    .AResetHN   (rst_n),
    .AClkHEn    (en),
    .AIoAddr    (addr),
    .AIoMiso    (miso),
    .AIoMosi    (mosi),
    .AIoWrSize  (wr_size),
    .AIoRdSize  (rd_size),
    .AIoAddrAck (ack),
    .AIoAddrErr (err),
    .ATest16p   (test),
    .ABusy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  wr_size;
    logic [3:0]  rd_size;
    logic [63:0] mosi;
    logic        exp_ack;
    logic        exp_err;
    logic [63:0] exp_miso;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    addr    = 16'h0000;
    wr_size = 4'h0;
    rd_size = 4'h0;
    mosi    = 64'h0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [3:0] sz, input logic [63:0] d);
    addr = a; wr_size = sz; mosi = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic peek_status(input string name, input logic [7:0] exp);
    addr = 16'h0000; rd_size = 4'b0001;
    #1;
    check(name, miso, {56'h0, exp});
    bus_idle();
  endtask

  task automatic data_read(input string name, input logic [15:0] exp);
    addr = 16'h0002; rd_size = 4'b0010;
    #1;
    check(name, miso, {48'h0, exp});
    @(negedge clk);
    bus_idle();
  endtask

  task automatic run_samples(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      test = base + 16'(i);
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            addr      wr     rd     mosi                   ack   err   miso   busy
    vecs[0]  = '{16'h0000, 4'h0, 4'h1, 64'h0,                  1'b1, 1'b0, 64'h0, 1'b0};
    vecs[1]  = '{16'h0000, 4'h2, 4'h0, 64'h1,                  1'b0, 1'b1, 64'h0, 1'b0};
    vecs[2]  = '{16'h0002, 4'h0, 4'h1, 64'h0,                  1'b0, 1'b1, 64'h0, 1'b0};
    vecs[3]  = '{16'h0003, 4'h0, 4'h2, 64'h0,                  1'b0, 1'b0, 64'h0, 1'b0};
    vecs[4]  = '{16'h0003, 4'h1, 4'h0, 64'h1,                  1'b0, 1'b0, 64'h0, 1'b0};
    vecs[5]  = '{16'h0000, 4'h4, 4'h0, 64'h1,                  1'b0, 1'b1, 64'h0, 1'b0};
    vecs[6]  = '{16'h0001, 4'h2, 4'h0, 64'h0000_0000_FFFF_1234, 1'b0, 1'b1, 64'h0, 1'b0};
    vecs[7]  = '{16'h0001, 4'h0, 4'h4, 64'h0,                  1'b0, 1'b1, 64'h0, 1'b0};
    vecs[8]  = '{16'h0002, 4'h0, 4'h2, 64'h0,                  1'b1, 1'b0, 64'h0, 1'b0};
    vecs[9]  = '{16'h0000, 4'h0, 4'h2, 64'h0,                  1'b0, 1'b1, 64'h0, 1'b0};
    vecs[10] = '{16'h0000, 4'h3, 4'h0, 64'h1,                  1'b0, 1'b1, 64'h0, 1'b0};
    vecs[11] = '{16'h0000, 4'h8, 4'h0, 64'h1,                  1'b0, 1'b1, 64'h0, 1'b0};
    vecs[12] = '{16'h0004, 4'h1, 4'h0, 64'h1,                  1'b0, 1'b0, 64'h0, 1'b0};
    vecs[13] = '{16'h0000, 4'h0, 4'h0, 64'h0,                  1'b0, 1'b0, 64'h0, 1'b0};
    vecs[14] = '{16'h0000, 4'h1, 4'h0, 64'h0,                  1'b1, 1'b0, 64'h0, 1'b0};
    vecs[15] = '{16'hFFFF, 4'h0, 4'h1, 64'h0,                  1'b0, 1'b0, 64'h0, 1'b0};
    vecs[16] = '{16'h0000, 4'h0, 4'h1, 64'h0,                  1'b1, 1'b0, 64'h0, 1'b0};

    rst_n = 1'b0;
    en    = 1'b1;
    test  = 16'h0000;
    bus_idle();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    peek_status("reset_status", 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Register access table in IDLE
    for (int v = 0; v < 17; v++) begin
      addr = vecs[v].addr; wr_size = vecs[v].wr_size; rd_size = vecs[v].rd_size; mosi = vecs[v].mosi;
      #1;
      check($sformatf("vec%0d_ack", v), {63'h0, ack}, {63'h0, vecs[v].exp_ack});
      check($sformatf("vec%0d_err", v), {63'h0, err}, {63'h0, vecs[v].exp_err});
      check($sformatf("vec%0d_miso", v), miso, vecs[v].exp_miso);
      @(negedge clk);
      bus_idle();
      check($sformatf("vec%0d_busy", v), {63'h0, busy}, {63'h0, vecs[v].exp_busy});
    end

    // Mask 0, incrementing count from 16'h0100
    io_write(16'h0001, 4'b0100, 64'h0);
    io_write(16'h0000, 4'b0001, 64'h1);
    peek_status("a_armed", 8'h01);
    check("a_busy_armed", {63'h0, busy}, 64'h1);
    run_samples(63, 16'h0100);
    check("a_busy_before_last", {63'h0, busy}, 64'h1);
    peek_status("a_capture_before_last", 8'h02);
    run_samples(1, 16'h013F);
    peek_status("a_done", 8'h04);
    check("a_busy_done", {63'h0, busy}, 64'h0);
    for (int k = 0; k < 64; k++) data_read($sformatf("a_data%0d", k), 16'h0100 + 16'(k));
    data_read("a_data64_empty", 16'h0000);
    data_read("a_data65_empty", 16'h0000);

    // Value 00A5 under mask 00FF
    io_write(16'h0001, 4'b0100, 64'h0000_0000_00FF_00A5);
    test = 16'h1200;
    io_write(16'h0000, 4'b0001, 64'h1);
    @(negedge clk);
    peek_status("b_no_trig", 8'h01);
    test = 16'h34A5;
    @(negedge clk);
    peek_status("b_trig", 8'h02);
    run_samples(62, 16'h5000);
    peek_status("b_not_yet_done", 8'h02);
    run_samples(1, 16'h503E);
    peek_status("b_done", 8'h04);
    data_read("b_first", 16'h34A5);
    data_read("b_second", 16'h5000);

    // Clock enable toggling: one sample per enabled cycle
    io_write(16'h0001, 4'b0100, 64'h0);
    io_write(16'h0000, 4'b0001, 64'h1);
    for (int i = 0; i < 128; i++) begin
      en   = (i % 2 == 0);
      test = 16'h2000 + 16'(i);
      if (i == 126) check("c_busy_before_last", {63'h0, busy}, 64'h1);
      if (i == 127) check("c_busy_after_last", {63'h0, busy}, 64'h0);
      @(negedge clk);
    end
    en = 1'b1;
    peek_status("c_done", 8'h04);
    for (int k = 0; k < 64; k++) data_read($sformatf("c_data%0d", k), 16'h2000 + 16'(2 * k));
    data_read("c_empty", 16'h0000);

    // Abort after 10 samples, arm+abort together, then re-arm
    io_write(16'h0000, 4'b0001, 64'h1);
    run_samples(10, 16'h3000);
    peek_status("d_capturing", 8'h02);
    test = 16'h3999;
    io_write(16'h0000, 4'b0001, 64'h2);
    peek_status("d_aborted", 8'h00);
    check("d_busy_aborted", {63'h0, busy}, 64'h0);
    data_read("d_data_idle", 16'h0000);
    io_write(16'h0000, 4'b0001, 64'h3);
    peek_status("d_arm_abort", 8'h00);
    io_write(16'h0000, 4'b0001, 64'h1);
    run_samples(64, 16'h4000);
    peek_status("d_redone", 8'h04);
    for (int k = 0; k < 64; k++) data_read($sformatf("d_data%0d", k), 16'h4000 + 16'(k));

    // Asynchronous reset during capture
    io_write(16'h0000, 4'b0001, 64'h1);
    run_samples(5, 16'h6000);
    check("e_busy_capture", {63'h0, busy}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("e_busy_in_reset", {63'h0, busy}, 64'h0);
    peek_status("e_status_in_reset", 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_samples(10, 16'h7000);
    peek_status("e_status_after", 8'h00);
    check("e_busy_after", {63'h0, busy}, 64'h0);
    data_read("e_data_after", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_test_scope.md
IO_TEST_SCOPE -- requirements
Module: io_test_scope

Interface
REQ-001 Parameter CAddrBase, default 16'h0000: IO base address; offsets 0..2 used.
REQ-002 Parameter CDepthLog2, default 6: capture depth is 2^CDepthLog2 samples of 16 bits (64 by default).
REQ-003 AClkH  input  1  sole clock; all state changes on rising edge.
REQ-004 AResetHN  input  1  reset, asynchronous, active-low.
REQ-005 AClkHEn  input  1  clock enable; state advances only when 1.
REQ-006 AIoAddr  input  16  IO address.
REQ-007 AIoMiso  output  64  IO read data.
REQ-008 AIoMosi  input  64  IO write data.
REQ-009 AIoWrSize  input  4  one-hot write size: bit0 byte, bit1 word, bit2 dword, bit3 qword; 0 means no write.
REQ-010 AIoRdSize  input  4  one-hot read size, same encoding; 0 means no read.
REQ-011 AIoAddrAck  output  1  access hits a register with an allowed size.
REQ-012 AIoAddrErr  output  1  access hits a register offset with a disallowed size.
REQ-013 ATest16p  input  16  test vector produced by the 16-channel test mux.
REQ-014 ABusy  output  1  high in ARMED or CAPTURE.

Function
REQ-015 Register map, with only the listed accesses legal:
- Offset 0 byte write: CMD, bit0 arm, bit1 abort.
- Offset 0 byte read: STATUS = {5'h0, Done, Capture, Armed}.
- Offset 1 dword write: TRIG, [15:0] value, [31:16] mask.
- Offset 2 word read: DATA, returns the next sample.
REQ-016 Any other size at offsets 0..2 shall assert AIoAddrErr and not AIoAddrAck, with no side effect. Addresses outside offsets 0..2 shall assert neither.
REQ-017 AIoAddrAck, AIoAddrErr and AIoMiso shall be combinational on the current access.
- AIoMiso is 0 when no legal read is present.
- Byte reads appear on [7:0], word reads on [15:0], all other bits 0.
REQ-018 FSM states IDLE, ARMED, CAPTURE, DONE. All transitions occur only on edges with AClkHEn=1.
REQ-019 CMD arm from any state: clear write pointer and read pointer, go to ARMED.
REQ-020 CMD abort from any state: go to IDLE, pointers unchanged. If arm and abort are set together, abort wins.
REQ-021 Trigger condition in ARMED: (ATest16p & mask) == (value & mask). Mask 0 triggers on the first enabled cycle after arming.
REQ-022 On the trigger cycle, store ATest16p at address 0, set write pointer to 1, go to CAPTURE.
REQ-023 In CAPTURE, each enabled cycle stores ATest16p at the write pointer and increments it.
- The write storing address 2^CDepthLog2-1 moves the FSM to DONE; no sample is ever overwritten.
- Total samples stored = 2^CDepthLog2, contiguous, trigger sample first.
REQ-024 A TRIG write takes effect on the next enabled edge and may occur in any state; the new value applies from the following sample onward.
REQ-025 DATA read in DONE returns buffer[read pointer] combinationally; read pointer increments on the access edge.
- Read pointer width is CDepthLog2+1.
- Once the read pointer equals 2^CDepthLog2, DATA reads return 16'h0 and the pointer holds.
REQ-026 DATA read outside DONE returns 16'h0 and leaves the read pointer unchanged.
REQ-027 An arm issued in the same cycle as a DATA read: the read returns current data and arm takes priority for pointer update (both pointers become 0).
REQ-028 The buffer shall be a 2^CDepthLog2 x 16 memory and shall be readable without a wait state.

Reset
REQ-029 While AResetHN=0: state IDLE, pointers 0, TRIG value and mask 0, ABusy 0, STATUS 8'h00. Buffer contents are undefined.
REQ-030 Reset deassertion mid-capture shall leave the block in IDLE, with DONE not set until the next arm.

Verification
REQ-031 Write TRIG mask 0; arm; drive ATest16p = incrementing count from 16'h0100 -> DONE after 64 enabled cycles; 64 DATA reads return 16'h0100..16'h013F; 65th read returns 16'h0000.
REQ-032 Write TRIG value 16'h00A5, mask 16'h00FF; arm; drive 16'h1200 then 16'h34A5 -> no capture on 16'h1200; first DATA read returns 16'h34A5; STATUS 8'h04 once done.
REQ-033 Arm, then toggle AClkHEn 1/0 alternately -> exactly 64 samples stored, one per enabled cycle; ABusy=1 until DONE.
REQ-034 Abort in CAPTURE after 10 samples -> STATUS 8'h00; DATA read returns 16'h0000; a re-arm restarts capture at address 0.
REQ-035 Word write to offset 0, byte read at offset 2, any access at offset 3 -> AIoAddrErr=1 for the first two; offset 3 gives Ack=0 and Err=0; state unchanged.
REQ-036 Assert AResetHN=0 during CAPTURE -> all outputs at reset values asynchronously; after release, STATUS 8'h00.
